// File: rtl/lc4_divider_iter.sv
// Iterative restoring unsigned divider (DIV/MOD) for the LC4 execute stage.
// Latency: WIDTH cycles from accept to o_valid; divide-by-zero reaches DONE in one cycle.
// Backpressure: result held in DONE until i_ready; o_ready only in IDLE.
module lc4_divider_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;

    logic [WIDTH-1:0] trial;
    logic [WIDTH:0]   diff;
    logic             last_step;
    logic             unused_rem_msb;

    // The partial remainder entering the final step is below 2^(WIDTH-1), so its MSB never matters.
    assign trial          = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
    assign diff           = {1'b0, trial} + {1'b0, ~dsr_q} + {{WIDTH{1'b0}}, 1'b1};
    assign last_step      = (cnt_q == CW'(WIDTH - 1));
    assign unused_rem_msb = rem_q[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_valid) state_d = (i_divisor == '0) ? DONE : RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    if (i_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        quo_d = quo_q;
        rem_d = rem_q;
        dvd_d = dvd_q;
        dsr_d = dsr_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    if (i_divisor != '0) begin
                        dvd_d = i_dividend;
                        dsr_d = i_divisor;
                        rem_d = '0;
                        cnt_d = '0;
                    end else begin
                        quo_d = '0;
                        rem_d = '0;
                    end
                end
            end
            RUN: begin
                dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                rem_d = diff[WIDTH] ? diff[WIDTH-1:0] : trial;
                quo_d = {quo_q[WIDTH-2:0], diff[WIDTH]};
                cnt_d = cnt_q + CW'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        o_ready     = (state_q == IDLE);
        o_valid     = (state_q == DONE);
        o_quotient  = quo_q;
        o_remainder = rem_q;
    end

endmodule

// File: tb/tb_lc4_divider_iter.sv
// Randomised and directed bench for lc4_divider_iter against a plain arithmetic model.
module tb_lc4_divider_iter;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_valid = 1'b0;
    logic         i_ready = 1'b0;
    logic [W-1:0] i_dividend = '0;
    logic [W-1:0] i_divisor = '0;
    logic         o_ready, o_valid;
    logic [W-1:0] o_quotient, o_remainder;

    int checks = 0;
    int errors = 0;

    lc4_divider_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_dividend(i_dividend), .i_divisor(i_divisor),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_quotient(o_quotient), .o_remainder(o_remainder)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        if (b == 0) begin
            q = '0;
            r = '0;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Issues one operation and collects observations; callers do the comparing.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                          input bit noise,
                          output logic [W-1:0] q, output logic [W-1:0] r, output int lat,
                          output bit to, output bit stable, output bit rdy_in_done,
                          output bit rdy_after);
        int n;
        to = 0; stable = 1; rdy_in_done = 0; rdy_after = 0; lat = 0; q = '0; r = '0;
        n = 0;
        while (!o_ready && n < 64) begin @(posedge clk); #1; n++; end
        if (!o_ready) begin to = 1; return; end
        i_valid = 1; i_dividend = a; i_divisor = b; i_ready = 0;
        @(posedge clk); #1;
        i_valid = 0;
        while (!o_valid && lat < 64) begin
            if (noise) begin i_valid = 1'($urandom_range(0, 1)); i_dividend = 9; i_divisor = 2; end
            else begin i_dividend = W'($urandom); i_divisor = W'($urandom); end
            @(posedge clk); #1;
            lat++;
        end
        if (!o_valid) begin to = 1; i_valid = 0; return; end
        q = o_quotient;
        r = o_remainder;
        for (int k = 0; k < hold; k++) begin
            if (noise) begin i_valid = 1'($urandom_range(0, 1)); i_dividend = 9; i_divisor = 2; end
            if (o_ready) rdy_in_done = 1;
            @(posedge clk); #1;
            if (!o_valid || o_quotient !== q || o_remainder !== r) stable = 0;
        end
        if (o_ready) rdy_in_done = 1;
        i_valid = 0;
        i_ready = 1;
        @(posedge clk); #1;
        i_ready = 0;
        rdy_after = o_ready;
    endtask

    task automatic test_reset();
        rst_n = 0;
        #12;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        checks++; if (o_quotient !== '0) begin errors++; $display("FAIL reset_q: got %0d want 0", o_quotient); end
        checks++; if (o_remainder !== '0) begin errors++; $display("FAIL reset_r: got %0d want 0", o_remainder); end
        @(posedge clk); #1;
        rst_n = 1;
        #1;
        checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0)
            begin errors++; $display("FAIL release_hs: ready=%b valid=%b want 1/0", o_ready, o_valid); end
    endtask

    task automatic test_basic();
        logic [W-1:0] q, r; int lat; bit to, st, rid, ra;
        run_op(16'd100, 16'd7, 0, 0, q, r, lat, to, st, rid, ra);
        checks++; if (to) begin errors++; $display("FAIL basic_timeout: got timeout want result"); end
        checks++; if (q !== 16'd14 || r !== 16'd2) begin errors++; $display("FAIL basic_qr: got q=%0d r=%0d want 14/2", q, r); end
        checks++; if (lat != W) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, W); end
        checks++; if (ra !== 1'b1) begin errors++; $display("FAIL basic_ready_after: got %b want 1", ra); end
    endtask

    task automatic test_edges();
        logic [W-1:0] av [4] = '{16'hFFFF, 16'd3, 16'hFFFF, 16'h8000};
        logic [W-1:0] bv [4] = '{16'd1, 16'd10, 16'hFFFF, 16'd3};
        logic [W-1:0] qv [4] = '{16'hFFFF, 16'd0, 16'd1, 16'd10922};
        logic [W-1:0] rv [4] = '{16'd0, 16'd3, 16'd0, 16'd2};
        logic [W-1:0] q, r; int lat; bit to, st, rid, ra;
        for (int i = 0; i < 4; i++) begin
            run_op(av[i], bv[i], 0, 0, q, r, lat, to, st, rid, ra);
            checks++; if (to || q !== qv[i] || r !== rv[i] || lat != W)
                begin errors++; $display("FAIL edge_%0d: got q=%0d r=%0d lat=%0d to=%b want q=%0d r=%0d lat=%0d",
                                         i, q, r, lat, to, qv[i], rv[i], W); end
        end
    endtask

    task automatic test_div_zero();
        logic [W-1:0] q, r; int lat; bit to, st, rid, ra;
        run_op(16'd1234, 16'd0, 0, 0, q, r, lat, to, st, rid, ra);
        checks++; if (to || q !== '0 || r !== '0) begin errors++; $display("FAIL div0_qr: got q=%0d r=%0d to=%b want 0/0", q, r, to); end
        checks++; if (lat != 0) begin errors++; $display("FAIL div0_latency: got %0d edges want 0 after accept", lat); end
        checks++; if (rid !== 1'b0) begin errors++; $display("FAIL div0_ready_in_done: got %b want 0", rid); end
        checks++; if (ra !== 1'b1) begin errors++; $display("FAIL div0_ready_after: got %b want 1", ra); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] q, r; int lat; bit to, st, rid, ra;
        run_op(16'd100, 16'd7, 5, 1, q, r, lat, to, st, rid, ra);
        checks++; if (to || q !== 16'd14 || r !== 16'd2)
            begin errors++; $display("FAIL bp_qr: got q=%0d r=%0d to=%b want 14/2", q, r, to); end
        checks++; if (lat != W) begin errors++; $display("FAIL bp_latency: got %0d want %0d", lat, W); end
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL bp_stable: got %b want 1", st); end
        checks++; if (rid !== 1'b0) begin errors++; $display("FAIL bp_ready_in_done: got %b want 0", rid); end
        checks++; if (ra !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b want 1", ra); end
    endtask

    task automatic test_reset_midop();
        logic [W-1:0] q, r; int lat; bit to, st, rid, ra;
        int n = 0;
        while (!o_ready && n < 64) begin @(posedge clk); #1; n++; end
        i_valid = 1; i_dividend = 16'd100; i_divisor = 16'd7;
        @(posedge clk); #1;
        i_valid = 0;
        repeat (8) begin @(posedge clk); #1; end
        #2 rst_n = 0;
        #1;
        checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1)
            begin errors++; $display("FAIL midrst_hs: valid=%b ready=%b want 0/1", o_valid, o_ready); end
        checks++; if (o_quotient !== '0 || o_remainder !== '0)
            begin errors++; $display("FAIL midrst_qr: got q=%0d r=%0d want 0/0", o_quotient, o_remainder); end
        @(posedge clk); #1;
        rst_n = 1;
        run_op(16'd50, 16'd5, 0, 0, q, r, lat, to, st, rid, ra);
        checks++; if (to || q !== 16'd10 || r !== 16'd0 || lat != W)
            begin errors++; $display("FAIL midrst_after: got q=%0d r=%0d lat=%0d to=%b want 10/0 lat %0d", q, r, lat, to, W); end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, q, r, eq, er; int lat; bit to, st, rid, ra;
        for (int i = 0; i < 1500; i++) begin
            a = W'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       b = a;
                default: b = W'($urandom);
            endcase
            run_op(a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)), q, r, lat, to, st, rid, ra);
            ref_div(a, b, eq, er);
            checks++; if (to || q !== eq || r !== er)
                begin errors++; $display("FAIL rand_qr: %0d/%0d got q=%0d r=%0d to=%b want q=%0d r=%0d", a, b, q, r, to, eq, er); end
            checks++; if (lat != ((b == 0) ? 0 : W))
                begin errors++; $display("FAIL rand_latency: %0d/%0d got %0d want %0d", a, b, lat, (b == 0) ? 0 : W); end
            checks++; if (st !== 1'b1 || rid !== 1'b0)
                begin errors++; $display("FAIL rand_hold: stable=%b ready_in_done=%b want 1/0", st, rid); end
            if (b != 0) begin
                checks++; if ((32'(q) * 32'(b) + 32'(r)) != 32'(a) || r >= b)
                    begin errors++; $display("FAIL rand_invariant: %0d/%0d got q=%0d r=%0d", a, b, q, r); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_div_zero();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
